// File: rtl/core_defs_pkg.sv
// rtl/core_defs_pkg.sv - shared RV32I core widths, ALU op codes and bubble values
package core_defs_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_SRL  = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;

   // A bubble is all-zero except the ALU op, so an idle ALU computes 0 + 0.
   localparam logic [3:0] BUBBLE_ALU_CONTROL = ALU_ADD;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_EXM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX/MEM and MEM/WB bypass select for two source registers
module forward_unit
   import core_defs_pkg::*;
#(
   parameter int REG_ADDR_W = core_defs_pkg::REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic [REG_ADDR_W-1:0] exm_rd_i,
   input  logic                  exm_reg_write_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic                  wb_reg_write_i,
   output fwd_sel_e              rs1_sel_o,
   output fwd_sel_e              rs2_sel_o
);

   logic exm_live;
   logic wb_live;

   // x0 is hardwired to zero, so a write to it must never be bypassed.
   assign exm_live = exm_reg_write_i && (exm_rd_i != '0);
   assign wb_live  = wb_reg_write_i && (wb_rd_i != '0);

   always_comb begin
      rs1_sel_o = FWD_REG;
      rs2_sel_o = FWD_REG;
      if (exm_live && (exm_rd_i == rs1_i))     rs1_sel_o = FWD_EXM;
      else if (wb_live && (wb_rd_i == rs1_i))  rs1_sel_o = FWD_WB;
      if (exm_live && (exm_rd_i == rs2_i))     rs2_sel_o = FWD_EXM;
      else if (wb_live && (wb_rd_i == rs2_i))  rs2_sel_o = FWD_WB;
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register, operand forwarding and load-use stall
module id_ex_operand_stage
   import core_defs_pkg::*;
#(
   parameter int XLEN       = core_defs_pkg::XLEN,
   parameter int REG_ADDR_W = core_defs_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [3:0]            id_alu_control,
   input  logic                  id_alu_src,
   input  logic                  id_a_sel_pc,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  flush,
   input  logic                  ex_stall,
   input  logic [REG_ADDR_W-1:0] exm_rd,
   input  logic                  exm_reg_write,
   input  logic [XLEN-1:0]       exm_result,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   input  logic [XLEN-1:0]       wb_data,
   output logic [XLEN-1:0]       alu_a,
   output logic [XLEN-1:0]       alu_b,
   output logic [3:0]            alu_control,
   output logic [XLEN-1:0]       ex_store_data,
   output logic [XLEN-1:0]       ex_pc,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_valid,
   output logic                  hazard_stall
);

   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       pc;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
      logic [XLEN-1:0]       imm;
      logic [3:0]            alu_control;
      logic                  alu_src;
      logic                  a_sel_pc;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
   } stage_t;

   stage_t   stage_q, stage_d, bubble, incoming;
   fwd_sel_e rs1_sel, rs2_sel;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

   always_comb begin
      bubble             = '0;
      bubble.alu_control = BUBBLE_ALU_CONTROL;
   end

   always_comb begin
      incoming = '{valid: id_valid, pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                   rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                   alu_control: id_alu_control, alu_src: id_alu_src,
                   a_sel_pc: id_a_sel_pc, reg_write: id_reg_write,
                   mem_read: id_mem_read, mem_write: id_mem_write};
   end

   // Only the instruction in EX can be a pending load; the bubble it causes clears it.
   always_comb begin
      hazard_stall = 1'b0;
      if (!reset && !flush && stage_q.valid && stage_q.mem_read && (stage_q.rd != '0) &&
          id_valid && ((stage_q.rd == id_rs1) || (stage_q.rd == id_rs2)))
         hazard_stall = 1'b1;
   end

   always_comb begin
      stage_d = incoming;
      if (reset || flush)     stage_d = bubble;
      else if (ex_stall)      stage_d = stage_q;
      else if (hazard_stall)  stage_d = bubble;
   end

   always_ff @(posedge clk) begin
      stage_q <= stage_d;
   end

   forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_forward_unit (
      .rs1_i           (stage_q.rs1),
      .rs2_i           (stage_q.rs2),
      .exm_rd_i        (exm_rd),
      .exm_reg_write_i (exm_reg_write),
      .wb_rd_i         (wb_rd),
      .wb_reg_write_i  (wb_reg_write),
      .rs1_sel_o       (rs1_sel),
      .rs2_sel_o       (rs2_sel)
   );

   always_comb begin
      case (rs1_sel)
         FWD_EXM: fwd_rs1 = exm_result;
         FWD_WB:  fwd_rs1 = wb_data;
         default: fwd_rs1 = stage_q.rs1_data;
      endcase
      case (rs2_sel)
         FWD_EXM: fwd_rs2 = exm_result;
         FWD_WB:  fwd_rs2 = wb_data;
         default: fwd_rs2 = stage_q.rs2_data;
      endcase
   end

   assign alu_a         = stage_q.a_sel_pc ? stage_q.pc  : fwd_rs1;
   assign alu_b         = stage_q.alu_src  ? stage_q.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign alu_control   = stage_q.alu_control;
   assign ex_pc         = stage_q.pc;
   assign ex_rd         = stage_q.rd;
   assign ex_reg_write  = stage_q.reg_write;
   assign ex_mem_read   = stage_q.mem_read;
   assign ex_mem_write  = stage_q.mem_write;
   assign ex_valid      = stage_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

   typedef struct {
      bit          valid;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic [3:0]  ctl;
      bit          src, asel, rw, mr, mw;
   } insn_t;

   logic        clk = 1'b0;
   logic        reset, flush, ex_stall;
   logic        id_valid, id_alu_src, id_a_sel_pc, id_reg_write, id_mem_read, id_mem_write;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_control;
   logic [4:0]  exm_rd, wb_rd;
   logic        exm_reg_write, wb_reg_write;
   logic [31:0] exm_result, wb_data;
   logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
   logic [3:0]  alu_control;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, hazard_stall;

   int total = 0;
   int bad   = 0;

   insn_t model;
   bit    model_live = 1'b0;

   id_ex_operand_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_a_sel_pc(id_a_sel_pc),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .flush(flush), .ex_stall(ex_stall),
      .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
      .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_valid(ex_valid), .hazard_stall(hazard_stall)
   );

   always #5 clk = ~clk;

   function automatic insn_t mk(bit v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                                logic [31:0] imm, logic [3:0] ctl, bit src, bit asel,
                                bit rw, bit mr, bit mw);
      insn_t i;
      i.valid = v; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
      i.d1 = d1; i.d2 = d2; i.imm = imm; i.ctl = ctl;
      i.src = src; i.asel = asel; i.rw = rw; i.mr = mr; i.mw = mw;
      return i;
   endfunction

   function automatic insn_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0);
   endfunction

   task automatic drive(input insn_t i);
      id_valid = i.valid; id_pc = i.pc; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
      id_rs1_data = i.d1; id_rs2_data = i.d2; id_imm = i.imm; id_alu_control = i.ctl;
      id_alu_src = i.src; id_a_sel_pc = i.asel; id_reg_write = i.rw;
      id_mem_read = i.mr; id_mem_write = i.mw;
   endtask

   function automatic insn_t id_now();
      return mk(id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
                id_alu_control, id_alu_src, id_a_sel_pc, id_reg_write, id_mem_read, id_mem_write);
   endfunction

   // Value an instruction in EX sees for a source register, newest producer first.
   function automatic logic [31:0] operand(logic [4:0] rs, logic [31:0] file_val);
      if (rs == 5'd0) return file_val;
      if (exm_reg_write && exm_rd == rs) return exm_result;
      if (wb_reg_write && wb_rd == rs) return wb_data;
      return file_val;
   endfunction

   function automatic bit load_use_expected();
      if (reset || flush) return 0;
      if (!(model.valid && model.mr && model.rd != 0 && id_valid)) return 0;
      return (model.rd == id_rs1) || (model.rd == id_rs2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (reset || flush)           model = nop();
      else if (ex_stall)            model = model;
      else if (load_use_expected()) model = nop();
      else                          model = id_now();
      if (reset) model_live = 1'b1;
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("m_alu_a", alu_a, model.asel ? model.pc : operand(model.rs1, model.d1));
         chk("m_alu_b", alu_b, model.src ? model.imm : operand(model.rs2, model.d2));
         chk("m_store", ex_store_data, operand(model.rs2, model.d2));
         chk("m_ctl", {28'd0, alu_control}, {28'd0, model.ctl});
         chk("m_pc", ex_pc, model.pc);
         chk("m_rd", {27'd0, ex_rd}, {27'd0, model.rd});
         chk("m_ctrl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
             {28'd0, model.valid, model.rw, model.mr, model.mw});
         chk("m_hazard", {31'd0, hazard_stall}, {31'd0, load_use_expected()});
      end
   end

   initial begin
      reset = 1; flush = 0; ex_stall = 0;
      exm_rd = 0; exm_reg_write = 0; exm_result = 0;
      wb_rd = 0; wb_reg_write = 0; wb_data = 0;
      drive(mk(1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
               $urandom, 4'($urandom), 1, 1, 1, 1, 1));
      tick();
      drive(mk(1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
               $urandom, 4'($urandom), 1, 1, 1, 1, 1));
      tick();
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("rst_ctl", {28'd0, alu_control}, 32'd2);
      chk("rst_a", alu_a, 32'd0);
      chk("rst_b", alu_b, 32'd0);
      chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
      reset = 0;

      // plain issue: sub x3, x1, x2
      drive(mk(1, 32'h40, 1, 2, 3, 5, 7, 0, 4'b0110, 0, 0, 1, 0, 0));
      tick();
      chk("plain_a", alu_a, 32'd5);
      chk("plain_b", alu_b, 32'd7);
      chk("plain_ctl", {28'd0, alu_control}, 32'd6);
      chk("plain_valid", {31'd0, ex_valid}, 32'd1);

      // forwarding priority on rs1 = x3
      drive(mk(1, 32'h44, 3, 4, 8, 32'h99, 32'h44, 0, 4'b0010, 0, 0, 1, 0, 0));
      tick();
      exm_rd = 3; exm_reg_write = 1; exm_result = 32'h11;
      wb_rd = 3;  wb_reg_write = 1;  wb_data = 32'h22;
      #1 chk("fwd_exm", alu_a, 32'h11);
      exm_reg_write = 0;
      #1 chk("fwd_wb", alu_a, 32'h22);
      chk("fwd_b_reg", alu_b, 32'h44);
      drive(mk(1, 32'h48, 0, 4, 8, 32'h55, 32'h44, 0, 4'b0010, 0, 0, 1, 0, 0));
      exm_rd = 0; exm_reg_write = 1; wb_rd = 0;
      tick();
      chk("fwd_x0", alu_a, 32'h55);
      exm_reg_write = 0; wb_reg_write = 0;

      // load-use: lw x5; add x6, x5, x1
      drive(mk(1, 32'h50, 2, 0, 5, 32'h1000, 0, 0, 4'b0010, 1, 0, 1, 1, 0));
      tick();
      drive(mk(1, 32'h54, 5, 1, 6, 32'hdead, 32'd3, 0, 4'b0010, 0, 0, 1, 0, 0));
      #1 chk("lu_stall", {31'd0, hazard_stall}, 32'd1);
      tick();
      chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
      chk("lu_stall_off", {31'd0, hazard_stall}, 32'd0);
      wb_rd = 5; wb_reg_write = 1; wb_data = 32'h77;
      tick();
      chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
      chk("lu_add_rd", {27'd0, ex_rd}, 32'd6);
      chk("lu_fwd", alu_a, 32'h77);
      chk("lu_b", alu_b, 32'd3);
      wb_reg_write = 0;

      // flush beats ex_stall
      flush = 1; ex_stall = 1;
      tick();
      chk("flush_valid", {31'd0, ex_valid}, 32'd0);
      flush = 0; ex_stall = 0;
      drive(mk(1, 32'h60, 1, 2, 9, 32'ha, 32'hb, 0, 4'b0110, 0, 0, 1, 0, 1));
      tick();
      ex_stall = 1;
      drive(mk(1, 32'h64, 3, 4, 10, 32'h1, 32'h2, 0, 4'b0000, 0, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_a", alu_a, 32'ha);
         chk("hold_rd", {27'd0, ex_rd}, 32'd9);
         chk("hold_ctl", {28'd0, alu_control}, 32'd6);
         chk("hold_mw", {31'd0, ex_mem_write}, 32'd1);
      end
      ex_stall = 0;

      // ex_stall during a load-use pair keeps the stall raised
      drive(mk(1, 32'h70, 2, 0, 5, 0, 0, 32'h8, 4'b0010, 1, 0, 1, 1, 0));
      tick();
      ex_stall = 1;
      drive(mk(1, 32'h74, 1, 5, 6, 0, 0, 0, 4'b0010, 0, 0, 1, 0, 0));
      tick();
      chk("stall_haz_hold", {31'd0, hazard_stall}, 32'd1);
      chk("stall_haz_valid", {31'd0, ex_mem_read}, 32'd1);
      flush = 1;
      #1 chk("flush_masks_haz", {31'd0, hazard_stall}, 32'd0);
      tick();
      flush = 0; ex_stall = 0;

      // immediate / pc path
      drive(mk(1, 32'h100, 1, 7, 11, 32'd9, 32'h1234, 32'hFFFFFFFC, 4'b0010, 1, 1, 1, 0, 1));
      tick();
      chk("imm_a", alu_a, 32'h100);
      chk("imm_b", alu_b, 32'hFFFFFFFC);
      chk("imm_store", ex_store_data, 32'h1234);
      exm_rd = 7; exm_reg_write = 1; exm_result = 32'hBEEF;
      #1 chk("imm_store_fwd", ex_store_data, 32'hBEEF);
      chk("imm_b_keep", alu_b, 32'hFFFFFFFC);
      drive(nop());
      tick();
      exm_reg_write = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
